// File: rtl/wire_gate_pkg.sv
// rtl/wire_gate_pkg.sv - shared constants, stage-A payload type and LUT evaluation for wire_gate_slot
package wire_gate_pkg;

    localparam int MAX_OPERANDS = 4;
    localparam int STAT_W       = 32;
    localparam int MAX_LUT_W    = 2 ** MAX_OPERANDS;

    // Stage-A control payload, sized for the widest slot; narrower slots
    // zero-extend their LUT and operand bits into it.
    typedef struct packed {
        logic                    dst_en;
        logic [MAX_LUT_W-1:0]    lut;
        logic [MAX_OPERANDS-1:0] ops;
    } stage_a_ctrl_t;

    // Truth-table lookup; operand 0 is the index LSB.
    function automatic logic lut_eval(input logic [MAX_LUT_W-1:0]    lut,
                                      input logic [MAX_OPERANDS-1:0] operand_bits);
        return lut[operand_bits];
    endfunction

endpackage

// File: rtl/wire_operand_mux.sv
// rtl/wire_operand_mux.sv - combinational operand taps over the wire vector
//
// Ports:
//   wires   in  NUM_WIRES            wire vector
//   op_sel  in  NUM_OPERANDS*SEL_W   packed selects, operand k at [k*SEL_W +: SEL_W]
//   op_bits out NUM_OPERANDS         selected bits; a select >= NUM_WIRES reads 0
module wire_operand_mux #(
    parameter int NUM_WIRES    = 16,
    parameter int NUM_OPERANDS = 3,
    parameter int SEL_W        = $clog2(NUM_WIRES)
) (
    input  logic [NUM_WIRES-1:0]          wires,
    input  logic [NUM_OPERANDS*SEL_W-1:0] op_sel,
    output logic [NUM_OPERANDS-1:0]       op_bits
);

    // Matching against every legal wire index makes out-of-range selects
    // fall through to the zero default without a separate range compare.
    always_comb begin
        op_bits = '0;
        for (int k = 0; k < NUM_OPERANDS; k++) begin
            for (int w = 0; w < NUM_WIRES; w++) begin
                if (op_sel[k*SEL_W +: SEL_W] == SEL_W'(w)) begin
                    op_bits[k] = wires[w];
                end
            end
        end
    end

endmodule

// File: rtl/wire_gate_slot.sv
// rtl/wire_gate_slot.sv - two-stage handshaked wire select / LUT evaluate / write-back slot
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   in_valid/in_ready    upstream handshake
//   in_wires             wire vector
//   in_op_sel            operand selects, operand k at [k*SEL_W +: SEL_W]
//   in_dst_sel/in_dst_en destination wire and write-back enable
//   in_lut               truth table indexed by {op[N-1], ..., op[0]}
//   out_valid/out_ready  downstream handshake
//   out_wires/out_result updated wire vector and evaluated bit
//   stat_ops/stat_stalls handshake and stall counters (WIRE_GATE_SLOT_STATS_EN only)
module wire_gate_slot
    import wire_gate_pkg::*;
#(
    parameter int NUM_WIRES    = 16,
    parameter int NUM_OPERANDS = 3,
    parameter int SEL_W        = $clog2(NUM_WIRES),
    parameter int LUT_W        = 2 ** NUM_OPERANDS
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_WIRES-1:0]          in_wires,
    input  logic [NUM_OPERANDS*SEL_W-1:0] in_op_sel,
    input  logic [SEL_W-1:0]              in_dst_sel,
    input  logic                          in_dst_en,
    input  logic [LUT_W-1:0]              in_lut,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_WIRES-1:0]          out_wires,
    output logic                          out_result
`ifdef WIRE_GATE_SLOT_STATS_EN
    ,
    output logic [STAT_W-1:0]             stat_ops,
    output logic [STAT_W-1:0]             stat_stalls
`endif
);

    logic                    a_valid;
    logic [NUM_WIRES-1:0]    a_wires;
    logic [SEL_W-1:0]        a_dst_sel;
    stage_a_ctrl_t           a_ctrl;

    logic                    b_valid;
    logic [NUM_WIRES-1:0]    b_wires;
    logic                    b_result;

    logic                    a_adv;
    logic                    b_adv;
    logic [NUM_OPERANDS-1:0] op_bits;
    logic                    eval_bit;
    logic [NUM_WIRES-1:0]    wires_upd;

    assign b_adv    = !b_valid || out_ready;
    assign a_adv    = !a_valid || b_adv;
    assign in_ready = resetn && a_adv;

    wire_operand_mux #(
        .NUM_WIRES    (NUM_WIRES),
        .NUM_OPERANDS (NUM_OPERANDS),
        .SEL_W        (SEL_W)
    ) u_operand_mux (
        .wires   (in_wires),
        .op_sel  (in_op_sel),
        .op_bits (op_bits)
    );

    // Operands were sampled from the incoming vector in stage A, so a
    // destination that aliases an operand cannot feed back into the result.
    always_comb begin
        eval_bit  = lut_eval(a_ctrl.lut, a_ctrl.ops);
        wires_upd = a_wires;
        for (int w = 0; w < NUM_WIRES; w++) begin
            if (a_ctrl.dst_en && (a_dst_sel == SEL_W'(w))) begin
                wires_upd[w] = eval_bit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_valid   <= 1'b0;
            a_wires   <= '0;
            a_dst_sel <= '0;
            a_ctrl    <= '0;
            b_valid   <= 1'b0;
            b_wires   <= '0;
            b_result  <= 1'b0;
        end else begin
            if (a_adv) begin
                a_valid <= in_valid;
                if (in_valid) begin
                    a_wires       <= in_wires;
                    a_dst_sel     <= in_dst_sel;
                    a_ctrl.dst_en <= in_dst_en;
                    a_ctrl.lut    <= MAX_LUT_W'(in_lut);
                    a_ctrl.ops    <= MAX_OPERANDS'(op_bits);
                end
            end
            if (b_adv) begin
                b_valid <= a_valid;
                if (a_valid) begin
                    b_wires  <= wires_upd;
                    b_result <= eval_bit;
                end
            end
        end
    end

    assign out_valid  = b_valid;
    assign out_wires  = b_wires;
    assign out_result = b_result;

`ifdef WIRE_GATE_SLOT_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_ops    <= '0;
            stat_stalls <= '0;
        end else begin
            if (b_valid && out_ready) begin
                stat_ops <= stat_ops + STAT_W'(1);
            end
            if (b_valid && !out_ready) begin
                stat_stalls <= stat_stalls + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_wire_gate_slot.sv
// tb/tb_wire_gate_slot.sv - self-checking bench for wire_gate_slot (16-wire and 12-wire instances)
module tb_wire_gate_slot;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_wires;
    logic [11:0] in_op_sel;
    logic [3:0]  in_dst_sel;
    logic        in_dst_en;
    logic [7:0]  in_lut;

    logic        in_ready_a, out_valid_a, out_result_a;
    logic [15:0] out_wires_a;
    logic        in_ready_b, out_valid_b, out_result_b;
    logic [11:0] out_wires_b;
`ifdef WIRE_GATE_SLOT_STATS_EN
    logic [31:0] stat_ops_a, stat_stalls_a, stat_ops_b, stat_stalls_b;
`endif

    always #5 clk = ~clk;

    wire_gate_slot #(.NUM_WIRES(16), .NUM_OPERANDS(3)) u_a (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready_a),
        .in_wires   (in_wires),
        .in_op_sel  (in_op_sel),
        .in_dst_sel (in_dst_sel),
        .in_dst_en  (in_dst_en),
        .in_lut     (in_lut),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready),
        .out_wires  (out_wires_a),
        .out_result (out_result_a)
`ifdef WIRE_GATE_SLOT_STATS_EN
        ,
        .stat_ops    (stat_ops_a),
        .stat_stalls (stat_stalls_a)
`endif
    );

    wire_gate_slot #(.NUM_WIRES(12), .NUM_OPERANDS(3)) u_b (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready_b),
        .in_wires   (in_wires[11:0]),
        .in_op_sel  (in_op_sel),
        .in_dst_sel (in_dst_sel),
        .in_dst_en  (in_dst_en),
        .in_lut     (in_lut),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready),
        .out_wires  (out_wires_b),
        .out_result (out_result_b)
`ifdef WIRE_GATE_SLOT_STATS_EN
        ,
        .stat_ops    (stat_ops_b),
        .stat_stalls (stat_stalls_b)
`endif
    );

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_pop   = 0;
    int          n_stall = 0;
    logic        acc_a;
    logic        pend_a, pend_b;
    logic [16:0] hold_a, hold_b;
    logic [16:0] qa[$];
    logic [16:0] qb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: {result, wires} for an nw-wire slot, straight from the gate rules.
    function automatic logic [16:0] model(input int nw, input logic [15:0] w,
                                          input logic [11:0] sel, input logic [3:0] dst,
                                          input logic en, input logic [7:0] lut);
        logic [15:0] wm;
        int          idx;
        int          s;
        logic        r;
        wm = w;
        for (int i = nw; i < 16; i++) wm[i] = 1'b0;
        idx = 0;
        for (int k = 0; k < 3; k++) begin
            s = int'(sel[k*4 +: 4]);
            if (s < nw && wm[s]) idx += (1 << k);
        end
        r = lut[idx];
        if (en && int'(dst) < nw) wm[dst] = r;
        return {r, wm};
    endfunction

    task automatic rnd();
        in_wires   = 16'($urandom);
        in_op_sel  = 12'($urandom);
        in_dst_sel = 4'($urandom);
        in_dst_en  = 1'($urandom);
        in_lut     = 8'($urandom);
    endtask

    // Called just after a falling edge with inputs set: scores this cycle's
    // handshakes, then advances one clock.
    task automatic cycle();
        logic [16:0] obs_a, obs_b;
        #1;
        obs_a = {out_result_a, out_wires_a};
        obs_b = {out_result_b, 4'b0000, out_wires_b};
        acc_a = resetn && in_valid && in_ready_a;
        if (resetn) begin
            if (pend_a) begin
                check("stall_valid_a", 32'(out_valid_a), 32'd1);
                check("stall_hold_a", 32'(obs_a), 32'(hold_a));
            end
            if (pend_b) begin
                check("stall_hold_b", 32'(obs_b), 32'(hold_b));
            end
            if (in_valid && in_ready_a) qa.push_back(model(16, in_wires, in_op_sel, in_dst_sel, in_dst_en, in_lut));
            if (in_valid && in_ready_b) qb.push_back(model(12, in_wires, in_op_sel, in_dst_sel, in_dst_en, in_lut));
            if (out_valid_a && out_ready) begin
                if (qa.size() == 0) check("unexpected_out_a", 32'd0, 32'd1);
                else check("out_a", 32'(obs_a), 32'(qa.pop_front()));
                n_pop++;
            end
            if (out_valid_b && out_ready) begin
                if (qb.size() == 0) check("unexpected_out_b", 32'd0, 32'd1);
                else check("out_b", 32'(obs_b), 32'(qb.pop_front()));
            end
            pend_a = out_valid_a && !out_ready;
            pend_b = out_valid_b && !out_ready;
            if (pend_a) n_stall++;
            hold_a = obs_a;
            hold_b = obs_b;
        end else begin
            qa.delete();
            qb.delete();
            pend_a = 1'b0;
            pend_b = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic and_gate(input string tag);
        in_wires = 16'h0005; in_op_sel = 12'h220; in_lut = 8'h80;
        in_dst_sel = 4'd7; in_dst_en = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        check({tag, "_accept"}, 32'(acc_a), 32'd1);
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid_a), 32'd0);
        cycle();
        check({tag, "_lat2"}, 32'(out_valid_a), 32'd1);
        check({tag, "_wires_a"}, 32'(out_wires_a), 32'h0085);
        check({tag, "_res_a"}, 32'(out_result_a), 32'd1);
        check({tag, "_wires_b"}, 32'(out_wires_b), 32'h085);
        cycle();
    endtask

    initial begin : stim
        int sent;
        int c;
        int p0;
        resetn = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        pend_a = 1'b0; pend_b = 1'b0; acc_a = 1'b0;
        rnd();
        @(negedge clk);

        // Reset held with in_valid high.
        repeat (3) begin
            #1;
            check("rst_in_ready_a", 32'(in_ready_a), 32'd0);
            check("rst_in_ready_b", 32'(in_ready_b), 32'd0);
            cycle();
            check("rst_out_valid_a", 32'(out_valid_a), 32'd0);
            check("rst_out_wires_a", 32'(out_wires_a), 32'd0);
            check("rst_out_result_a", 32'(out_result_a), 32'd0);
            check("rst_out_valid_b", 32'(out_valid_b), 32'd0);
        end
        resetn = 1'b1; in_valid = 1'b0;
        cycle();
        check("post_rst_idle", 32'(out_valid_a), 32'd0);

        and_gate("and");

        // Pass-through.
        rnd();
        in_wires = 16'hBEEF; in_dst_en = 1'b0; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("pass_wires_a", 32'(out_wires_a), 32'hBEEF);
        check("pass_wires_b", 32'(out_wires_b), 32'hEEF);
        cycle();

        // Out-of-range select 13 and destination 14.
        in_wires = 16'h0FFF; in_op_sel = 12'h0D0; in_lut = 8'h20;
        in_dst_sel = 4'd14; in_dst_en = 1'b1; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("oor_wires_b", 32'(out_wires_b), 32'hFFF);
        check("oor_res_b", 32'(out_result_b), 32'd1);
        check("oor_wires_a", 32'(out_wires_a), 32'h4FFF);
        check("oor_res_a", 32'(out_result_a), 32'd1);
        cycle();

        // Backpressure: 10 transactions, out_ready low for 5 cycles mid-stream.
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        n_stall = 0;
        p0 = n_pop; sent = 0; c = 0;
        rnd();
        while ((n_pop - p0) < 10 && c < 300) begin
            in_valid  = (sent < 10);
            out_ready = !(c >= 4 && c < 9);
            cycle();
            if (acc_a) begin
                sent++;
                rnd();
            end
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_count", 32'(n_pop - p0), 32'd10);
        check("bp_stalls_model", 32'(n_stall), 32'd5);
`ifdef WIRE_GATE_SLOT_STATS_EN
        check("stat_ops_a", stat_ops_a, 32'd10);
        check("stat_stalls_a", stat_stalls_a, 32'(n_stall));
        check("stat_ops_b", stat_ops_b, 32'd10);
        check("stat_stalls_b", stat_stalls_b, 32'd5);
`endif
        cycle();

        // Random traffic on both handshakes.
        for (int i = 0; i < 200; i++) begin
            if (!in_valid || acc_a) rnd();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        c = 0;
        while ((qa.size() != 0 || qb.size() != 0) && c < 20) begin
            cycle();
            c++;
        end
        check("drain_a", 32'(qa.size()), 32'd0);
        check("drain_b", 32'(qb.size()), 32'd0);

        // Reset with both stages full.
        rnd();
        in_valid = 1'b1; out_ready = 1'b0;
        repeat (3) cycle();
        #1;
        check("full_out_valid", 32'(out_valid_a), 32'd1);
        check("full_in_ready", 32'(in_ready_a), 32'd0);
        resetn = 1'b0;
        cycle();
        check("midrst_out_valid_a", 32'(out_valid_a), 32'd0);
        check("midrst_out_valid_b", 32'(out_valid_b), 32'd0);
        resetn = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        check("midrst_idle", 32'(out_valid_a), 32'd0);
        and_gate("after_rst");
        check("final_q_a", 32'(qa.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
